// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the datapath / shared memory port.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsource;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  // Controller side: consumes opcode/handshake, drives every select and enable.
  modport master (
    input  opcode, mem_ready,
    output pcwrite, branch, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op, mem_timeout, state
  );

  // Datapath / memory side.
  modport slave (
    output opcode, mem_ready,
    input  pcwrite, branch, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle datapath: fetch, decode, execute, memory, writeback.
// Memory wait states are bounded by WAIT_LIMIT; an expired wait parks the FSM in HALT.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  multicycle_controller_if.master      bus
);

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StRtypeEx = 4'd7,
    StRtypeWb = 4'd8,
    StBeqEx   = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StJumpEx  = 4'd12,
    StHalt    = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // A zero-bit counter is not legal, so WAIT_LIMIT == 0 still gets one bit.
  localparam int unsigned CntW   = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
  localparam logic [CntW-1:0] CntSat = '1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              wait_state;
  logic              timeout_hit;

  // State, wait counter and sticky timeout flag; reset aborts any instruction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Next state, including the wait-timeout override and counter update.
  always_comb begin
    state_d     = state_q;
    wait_state  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // mem_ready in the final allowed cycle beats the timeout.
    timeout_hit = (WAIT_LIMIT != 0) && wait_state && !bus.mem_ready && (cnt_q == CntMax);

    unique case (state_q)
      StIdle:    state_d = StFetch;
      StFetch:   if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StRtypeEx;
          OpBeq:      state_d = StBeqEx;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJumpEx;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:  state_d = (bus.opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (bus.mem_ready) state_d = StFetch;
      StRtypeEx: state_d = StRtypeWb;
      StRtypeWb: state_d = StFetch;
      StBeqEx:   state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StJumpEx:  state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase

    if (timeout_hit) state_d = StHalt;

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_state && !bus.mem_ready && (cnt_q != CntSat)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    mem_timeout_d = mem_timeout_q | timeout_hit;
  end

  // Moore outputs per state; only FETCH and MEMWR qualify strobes with mem_ready.
  always_comb begin
    bus.pcwrite    = 1'b0;
    bus.branch     = 1'b0;
    bus.iord       = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.irwrite    = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regwrite   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.aluop      = 2'b00;
    bus.pcsource   = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;

    unique case (state_q)
      StFetch: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
      end
      StDecode: begin
        bus.alusrcb = 2'b11;
        unique case (bus.opcode)
          OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: bus.illegal_op = 1'b0;
          default:                                 bus.illegal_op = 1'b1;
        endcase
      end
      StMemAdr: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      StMemRd: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      StMemWb: begin
        bus.memtoreg   = 1'b1;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      StMemWr: begin
        bus.memwrite   = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      StRtypeEx: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      StRtypeWb: begin
        bus.regdst     = 1'b1;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      StBeqEx: begin
        bus.alusrca    = 1'b1;
        bus.aluop      = 2'b01;
        bus.branch     = 1'b1;
        bus.pcsource   = 2'b01;
        bus.instr_done = 1'b1;
      end
      StAddiEx: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      StAddiWb: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      StJumpEx: begin
        bus.pcwrite    = 1'b1;
        bus.pcsource   = 2'b10;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_timeout = mem_timeout_q;
  assign bus.state       = state_q;

endmodule
